// File: rtl/lsu_load_align.sv
// Load-return alignment stage: reorders the four bank bytes by address parity,
// sign/zero-extends by access size, and holds the result across writeback stalls.
module lsu_load_align #(
    parameter int ADDR_W    = 32,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [2:0]        i_bmask,
    input  logic              i_unsigned,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [7:0]        i_q_even_1,
    input  logic [7:0]        i_q_odd_1,
    input  logic [7:0]        i_q_even_2,
    input  logic [7:0]        i_q_odd_2,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_a0;
    logic [2:0]  r_bmask;
    logic        r_unsigned;
    logic [31:0] r_hold_data;
    logic        r_hold_err;

    logic        w_accept;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [31:0] w_asm_data;
    logic        w_asm_err;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_err;
    logic        w_addr_unused;

    function automatic logic bmask_legal(input logic [2:0] bm);
        return (bm == 3'b001) || (bm == 3'b010) || (bm == 3'b100);
    endfunction

    function automatic logic [31:0] extend_load(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [2:0] bm,
        input logic       sgn
    );
        logic [31:0] res;
        case (bm)
            3'b001:  res = {{24{sgn & b0[7]}}, b0};
            3'b010:  res = {{16{sgn & b1[7]}}, b1, b0};
            3'b100:  res = {b3, b2, b1, b0};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Only the parity of the address steers the byte lanes.
    assign w_addr_unused = ^i_lsu_addr[ADDR_W-1:1];

    assign w_accept = i_ld_req & ~i_stall & ~i_flush;

    // Odd addresses swap each even/odd bank pair.
    assign w_b0 = r_a0 ? i_q_odd_1  : i_q_even_1;
    assign w_b1 = r_a0 ? i_q_even_1 : i_q_odd_1;
    assign w_b2 = r_a0 ? i_q_odd_2  : i_q_even_2;
    assign w_b3 = r_a0 ? i_q_even_2 : i_q_odd_2;

    assign w_asm_err  = ~bmask_legal(r_bmask);
    assign w_asm_data = extend_load(w_b0, w_b1, w_b2, w_b3, r_bmask, ~r_unsigned);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_a0        <= 1'b0;
            r_bmask     <= 3'b000;
            r_unsigned  <= 1'b0;
            r_hold_data <= 32'd0;
            r_hold_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a0       <= i_lsu_addr[0];
                r_bmask    <= i_bmask;
                r_unsigned <= i_unsigned;
            end
            // Banks only drive valid data for one cycle, so capture before they move on.
            if (r_state == ST_DATA && i_stall) begin
                r_hold_data <= w_asm_data;
                r_hold_err  <= w_asm_err;
            end
            if (i_flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_DATA, ST_HOLD: begin
                        if (i_stall)       r_state <= ST_HOLD;
                        else if (w_accept) r_state <= ST_DATA;
                        else               r_state <= ST_IDLE;
                    end
                    default: r_state <= w_accept ? ST_DATA : ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_valid = 1'b0;
        w_data  = 32'd0;
        w_err   = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_valid = 1'b1;
                w_data  = w_asm_data;
                w_err   = w_asm_err;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                w_data  = r_hold_data;
                w_err   = r_hold_err;
            end
            default: begin
                w_valid = 1'b0;
                w_data  = ZERO_IDLE ? 32'd0 : w_asm_data;
                w_err   = 1'b0;
            end
        endcase
    end

    assign o_ld_valid = w_valid;
    assign o_ld_data  = w_data;
    assign o_ld_err   = w_err;

endmodule

// File: tb/tb_lsu_load_align.sv
// Scoreboard bench for lsu_load_align: directed loads push expected words,
// a negedge monitor pops and compares on every consumed delivery.
module tb_lsu_load_align;

    logic        clk;
    logic        rst_n;
    logic        i_ld_req;
    logic [31:0] i_lsu_addr;
    logic [2:0]  i_bmask;
    logic        i_unsigned;
    logic        i_stall;
    logic        i_flush;
    logic [7:0]  i_q_even_1;
    logic [7:0]  i_q_odd_1;
    logic [7:0]  i_q_even_2;
    logic [7:0]  i_q_odd_2;
    logic        o_ld_valid;
    logic [31:0] o_ld_data;
    logic        o_ld_err;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    lsu_load_align #(.ADDR_W(32), .ZERO_IDLE(1'b1)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_ld_req   (i_ld_req),
        .i_lsu_addr (i_lsu_addr),
        .i_bmask    (i_bmask),
        .i_unsigned (i_unsigned),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_q_even_1 (i_q_even_1),
        .i_q_odd_1  (i_q_odd_1),
        .i_q_even_2 (i_q_even_2),
        .i_q_odd_2  (i_q_odd_2),
        .o_ld_valid (o_ld_valid),
        .o_ld_data  (o_ld_data),
        .o_ld_err   (o_ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // banks packed as {odd_2, even_2, odd_1, even_1}
    task automatic drive(input logic req, input logic [31:0] addr, input logic [2:0] bm,
                         input logic uns, input logic stall, input logic flush,
                         input logic [31:0] banks);
        @(posedge clk);
        #1;
        i_ld_req   = req;
        i_lsu_addr = addr;
        i_bmask    = bm;
        i_unsigned = uns;
        i_stall    = stall;
        i_flush    = flush;
        i_q_even_1 = banks[7:0];
        i_q_odd_1  = banks[15:8];
        i_q_even_2 = banks[23:16];
        i_q_odd_2  = banks[31:24];
    endtask

    task automatic probe(input string name, input logic ev, input logic [31:0] ed);
        #1;
        chk({name, "_valid"}, {31'd0, o_ld_valid}, {31'd0, ev});
        chk({name, "_data"}, o_ld_data, ed);
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_ld_valid && !i_stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_delivery: got data %h err %0d, expected no delivery",
                         o_ld_data, o_ld_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("deliver_data", o_ld_data, mon_e.d);
                chk("deliver_err", {31'd0, o_ld_err}, {31'd0, mon_e.e});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        i_ld_req = 1'b0; i_lsu_addr = 32'd0; i_bmask = 3'b000; i_unsigned = 1'b0;
        i_stall = 1'b0; i_flush = 1'b0;
        i_q_even_1 = 8'd0; i_q_odd_1 = 8'd0; i_q_even_2 = 8'd0; i_q_odd_2 = 8'd0;
        #12;
        chk("reset_valid", {31'd0, o_ld_valid}, 32'd0);
        chk("reset_data", o_ld_data, 32'd0);
        chk("reset_err", {31'd0, o_ld_err}, 32'd0);
        rst_n = 1'b1;

        // lw aligned
        push(32'h44332211, 1'b0);
        drive(1, 32'h100, 3'b100, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h44332211);
        probe("lw_aligned", 1'b1, 32'h44332211);

        // lh / lhu at odd address
        push(32'hFFFFF234, 1'b0);
        drive(1, 32'h103, 3'b010, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h665534F2);
        push(32'h0000F234, 1'b0);
        drive(1, 32'h103, 3'b010, 1, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h665534F2);

        // lb / lbu at odd address
        push(32'hFFFFFF80, 1'b0);
        drive(1, 32'h101, 3'b001, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h0000807F);
        push(32'h00000080, 1'b0);
        drive(1, 32'h101, 3'b001, 1, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h0000807F);

        // back-to-back loads, banks of load k arrive with request k+1
        push(32'hCCDDAABB, 1'b0);
        drive(1, 32'h101, 3'b100, 0, 0, 0, 32'h0);
        push(32'hFFFF9ABC, 1'b0);
        drive(1, 32'h102, 3'b010, 0, 0, 0, 32'hDDCCBBAA);
        push(32'h00009ABC, 1'b0);
        drive(1, 32'h102, 3'b010, 1, 0, 0, 32'h00009ABC);
        push(32'h00000012, 1'b0);
        drive(1, 32'h100, 3'b001, 0, 0, 0, 32'h11229ABC);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'hFFFFFF12);
        probe("b2b_last", 1'b1, 32'h00000012);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h0);
        probe("b2b_idle", 1'b0, 32'h0);

        // stall for three cycles with scrambled banks; request during stall is ignored
        push(32'h04030201, 1'b0);
        drive(1, 32'h200, 3'b100, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 1, 0, 32'h04030201);
        probe("stall_data_st", 1'b1, 32'h04030201);
        drive(1, 32'h204, 3'b100, 0, 1, 0, 32'hDEADBEEF);
        probe("stall_hold1", 1'b1, 32'h04030201);
        drive(0, 32'h0, 3'b000, 0, 1, 0, 32'h12345678);
        probe("stall_hold2", 1'b1, 32'h04030201);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'hCAFEF00D);
        probe("stall_release", 1'b1, 32'h04030201);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'hCAFEF00D);
        probe("stall_once", 1'b0, 32'h0);

        // flush in DATA (stall held so the flushed word is not consumed)
        drive(1, 32'h300, 3'b100, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 1, 1, 32'h55555555);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h55555555);
        probe("flush_data", 1'b0, 32'h0);
        // request with flush is not accepted
        drive(1, 32'h300, 3'b100, 0, 0, 1, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h77777777);
        probe("flush_req", 1'b0, 32'h0);

        // illegal bmask, direct and through HOLD
        push(32'h0, 1'b1);
        drive(1, 32'h100, 3'b011, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h44332211);
        probe("illegal", 1'b1, 32'h0);
        push(32'h0, 1'b1);
        drive(1, 32'h101, 3'b000, 1, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 1, 0, 32'hFFFFFFFF);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h0);
        probe("illegal_hold", 1'b1, 32'h0);

        // async reset while in HOLD drops the load
        push(32'hA1B2C3D4, 1'b0);
        drive(1, 32'h400, 3'b100, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 1, 0, 32'hA1B2C3D4);
        drive(0, 32'h0, 3'b000, 0, 1, 0, 32'h01010101);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        probe("rst_hold", 1'b0, 32'h0);
        chk("rst_hold_err", {31'd0, o_ld_err}, 32'd0);
        #5;
        rst_n = 1'b1;
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'hA1B2C3D4);
        probe("post_rst", 1'b0, 32'h0);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'hA1B2C3D4);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 32'h0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
